// File: rtl/systolic_nbody_scheduler.sv
// Block/body sequencer for the 2x2 systolic n-body force array.
// Issues upper-triangular blocks, tracks them through the array, then integrates.
module systolic_nbody_scheduler #(
  parameter int NBLK     = 2,
  parameter int PIPE_LAT = 3,
  parameter int STEPS_W  = 16,
  parameter int IDX_W    = (NBLK > 1) ? $clog2(NBLK) : 1,
  parameter int BODY_W   = (2 * NBLK > 1) ? $clog2(2 * NBLK) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [STEPS_W-1:0] num_steps,
  output logic               busy,
  output logic               done,
  output logic [STEPS_W-1:0] step_count,
  output logic               acc_clr,
  output logic               blk_valid,
  input  logic               blk_ready,
  output logic [IDX_W-1:0]   blk_i,
  output logic [IDX_W-1:0]   blk_j,
  output logic               blk_diag,
  output logic               res_valid,
  output logic [IDX_W-1:0]   res_i,
  output logic [IDX_W-1:0]   res_j,
  output logic               res_diag,
  output logic               int_valid,
  input  logic               int_ready,
  output logic [BODY_W-1:0]  int_body
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] ISSUE = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] INTEG = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  localparam logic [IDX_W-1:0]  LAST_BLK  = IDX_W'(NBLK - 1);
  localparam logic [BODY_W-1:0] LAST_BODY = BODY_W'(2 * NBLK - 1);

  logic [2:0]          state;
  logic [STEPS_W-1:0]  steps_q;
  logic                blk_xfer;
  logic [PIPE_LAT-1:0] pv;
  logic [IDX_W-1:0]    pi [PIPE_LAT];
  logic [IDX_W-1:0]    pj [PIPE_LAT];
  logic [PIPE_LAT-1:0] pd;

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign acc_clr   = (state == CLEAR);
  assign blk_valid = (state == ISSUE);
  assign int_valid = (state == INTEG);
  assign blk_diag  = blk_valid && (blk_i == blk_j);
  assign blk_xfer  = blk_valid && blk_ready;

  assign res_valid = pv[PIPE_LAT-1];
  assign res_i     = pi[PIPE_LAT-1];
  assign res_j     = pj[PIPE_LAT-1];
  assign res_diag  = pd[PIPE_LAT-1];

  // In-flight tracker: empty stages carry zeroed indices.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      pd <= '0;
      for (int k = 0; k < PIPE_LAT; k++) begin
        pi[k] <= '0;
        pj[k] <= '0;
      end
    end else begin
      pv <= {pv[PIPE_LAT-2:0], blk_xfer};
      pd <= {pd[PIPE_LAT-2:0], blk_xfer && blk_diag};
      pi[0] <= blk_xfer ? blk_i : '0;
      pj[0] <= blk_xfer ? blk_j : '0;
      for (int k = 1; k < PIPE_LAT; k++) begin
        pi[k] <= pi[k-1];
        pj[k] <= pj[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      steps_q    <= '0;
      step_count <= '0;
      blk_i      <= '0;
      blk_j      <= '0;
      int_body   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            steps_q    <= num_steps;
            step_count <= '0;
            state      <= (num_steps != '0) ? CLEAR : DONE;
          end
        end
        CLEAR: begin
          blk_i <= '0;
          blk_j <= '0;
          state <= ISSUE;
        end
        ISSUE: begin
          if (blk_ready) begin
            if (blk_j == LAST_BLK) begin
              if (blk_i == LAST_BLK) begin
                state <= DRAIN;
              end else begin
                blk_i <= blk_i + 1'b1;
                blk_j <= blk_i + 1'b1;
              end
            end else begin
              blk_j <= blk_j + 1'b1;
            end
          end
        end
        DRAIN: begin
          // Last block sits in the final stage while the rest are empty.
          if (pv[PIPE_LAT-2:0] == '0) begin
            int_body <= '0;
            state    <= INTEG;
          end
        end
        INTEG: begin
          if (int_ready) begin
            if (int_body == LAST_BODY) begin
              if (step_count + 1'b1 == steps_q) begin
                state <= DONE;
              end else begin
                step_count <= step_count + 1'b1;
                state      <= CLEAR;
              end
            end else begin
              int_body <= int_body + 1'b1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_nbody_scheduler.sv
// Directed bench for systolic_nbody_scheduler: NBLK=2/PIPE_LAT=3 and
// NBLK=1/PIPE_LAT=2 instances driven from shared stimulus.
module tb_systolic_nbody_scheduler;

  typedef struct {
    logic       st, br, ir;
    logic       busy, done, acc, bv;
    logic [1:0] bi, bj;
    logic       bd, rv;
    logic [1:0] ri, rj;
    logic       rd, iv;
    logic [1:0] ib;
  } row_t;

  logic        clk = 0;
  logic        rst_n;
  logic        start;
  logic [15:0] num_steps;
  logic        blk_ready;
  logic        int_ready;

  logic        a_busy, a_done, a_acc, a_bv, a_bd, a_rv, a_rd, a_iv;
  logic [15:0] a_sc;
  logic        a_bi, a_bj, a_ri, a_rj;
  logic [1:0]  a_ib;
  logic        b_busy, b_done, b_acc, b_bv, b_bd, b_rv, b_rd, b_iv;
  logic [15:0] b_sc;
  logic        b_bi, b_bj, b_ri, b_rj;
  logic        b_ib;

  row_t tab [64];
  int   n = 0;
  int   sel = 0;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  systolic_nbody_scheduler #(.NBLK(2), .PIPE_LAT(3), .STEPS_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .num_steps(num_steps),
    .busy(a_busy), .done(a_done), .step_count(a_sc), .acc_clr(a_acc),
    .blk_valid(a_bv), .blk_ready(blk_ready), .blk_i(a_bi), .blk_j(a_bj),
    .blk_diag(a_bd), .res_valid(a_rv), .res_i(a_ri), .res_j(a_rj),
    .res_diag(a_rd), .int_valid(a_iv), .int_ready(int_ready),
    .int_body(a_ib)
  );

  systolic_nbody_scheduler #(.NBLK(1), .PIPE_LAT(2), .STEPS_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .num_steps(num_steps),
    .busy(b_busy), .done(b_done), .step_count(b_sc), .acc_clr(b_acc),
    .blk_valid(b_bv), .blk_ready(blk_ready), .blk_i(b_bi), .blk_j(b_bj),
    .blk_diag(b_bd), .res_valid(b_rv), .res_i(b_ri), .res_j(b_rj),
    .res_diag(b_rd), .int_valid(b_iv), .int_ready(int_ready),
    .int_body(b_ib)
  );

  task automatic chk(input string nm, input int c,
                     input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, act, exp);
    end
  endtask

  task automatic r(input logic st, br, ir, bs, dn, ac, bv,
                   input logic [1:0] bi, bj, input logic bd, rv,
                   input logic [1:0] ri, rj, input logic rd, iv,
                   input logic [1:0] ib);
    tab[n] = '{st, br, ir, bs, dn, ac, bv, bi, bj, bd, rv, ri, rj, rd, iv, ib};
    n++;
  endtask

  task automatic sample(output row_t o);
    o = '{default: '0};
    if (sel == 0) begin
      o.busy = a_busy; o.done = a_done; o.acc = a_acc; o.bv = a_bv;
      o.bi = {1'b0, a_bi}; o.bj = {1'b0, a_bj}; o.bd = a_bd;
      o.rv = a_rv; o.ri = {1'b0, a_ri}; o.rj = {1'b0, a_rj};
      o.rd = a_rd; o.iv = a_iv; o.ib = a_ib;
    end else begin
      o.busy = b_busy; o.done = b_done; o.acc = b_acc; o.bv = b_bv;
      o.bi = {1'b0, b_bi}; o.bj = {1'b0, b_bj}; o.bd = b_bd;
      o.rv = b_rv; o.ri = {1'b0, b_ri}; o.rj = {1'b0, b_rj};
      o.rd = b_rd; o.iv = b_iv; o.ib = {1'b0, b_ib};
    end
  endtask

  task automatic run_tab(input int lo, input int hi);
    row_t o;
    for (int k = lo; k <= hi; k++) begin
      @(negedge clk);
      start = tab[k].st; blk_ready = tab[k].br; int_ready = tab[k].ir;
      #1;
      sample(o);
      chk("busy", k - lo, o.busy, tab[k].busy);
      chk("done", k - lo, o.done, tab[k].done);
      chk("acc_clr", k - lo, o.acc, tab[k].acc);
      chk("blk_valid", k - lo, o.bv, tab[k].bv);
      chk("res_valid", k - lo, o.rv, tab[k].rv);
      chk("int_valid", k - lo, o.iv, tab[k].iv);
      if (tab[k].bv) begin
        chk("blk_i", k - lo, o.bi, tab[k].bi);
        chk("blk_j", k - lo, o.bj, tab[k].bj);
      end
      chk("blk_diag", k - lo, o.bd, tab[k].bd);
      if (tab[k].rv) begin
        chk("res_i", k - lo, o.ri, tab[k].ri);
        chk("res_j", k - lo, o.rj, tab[k].rj);
      end
      chk("res_diag", k - lo, o.rd, tab[k].rd);
      if (tab[k].iv) chk("int_body", k - lo, o.ib, tab[k].ib);
    end
    start = 0; blk_ready = 1; int_ready = 1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_a"}, 0, {a_busy, a_done, a_acc, a_bv, a_bi, a_bj, a_bd,
        a_rv, a_ri, a_rj, a_rd, a_iv, a_ib, a_sc}, 32'd0);
    chk({nm, "_b"}, 0, {b_busy, b_done, b_acc, b_bv, b_bi, b_bj, b_bd,
        b_rv, b_ri, b_rj, b_rd, b_iv, b_ib, b_sc}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] acc_m, done_m, busy_m;
    int          rv_n, ih_n;
    logic        act;

    // Scenario 1: NBLK=2, one step, no stalls (rows 0..13)
    r(1,1,1, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0);
    r(0,1,1, 1,0,1, 0,0,0,0, 0,0,0,0, 0,0);
    r(0,1,1, 1,0,0, 1,0,0,1, 0,0,0,0, 0,0);
    r(0,1,1, 1,0,0, 1,0,1,0, 0,0,0,0, 0,0);
    r(0,1,1, 1,0,0, 1,1,1,1, 0,0,0,0, 0,0);
    r(0,1,1, 1,0,0, 0,0,0,0, 1,0,0,1, 0,0);
    r(0,1,1, 1,0,0, 0,0,0,0, 1,0,1,0, 0,0);
    r(0,1,1, 1,0,0, 0,0,0,0, 1,1,1,1, 0,0);
    r(0,1,1, 1,0,0, 0,0,0,0, 0,0,0,0, 1,0);
    r(0,1,1, 1,0,0, 0,0,0,0, 0,0,0,0, 1,1);
    r(0,1,1, 1,0,0, 0,0,0,0, 0,0,0,0, 1,2);
    r(0,1,1, 1,0,0, 0,0,0,0, 0,0,0,0, 1,3);
    r(0,1,1, 1,1,0, 0,0,0,0, 0,0,0,0, 0,0);
    r(0,1,1, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0);
    // Scenario 2: blk_ready low cycles 2-3, int_ready low 11-12 (rows 14..31)
    r(1,1,1, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0);
    r(0,1,1, 1,0,1, 0,0,0,0, 0,0,0,0, 0,0);
    r(0,0,1, 1,0,0, 1,0,0,1, 0,0,0,0, 0,0);
    r(0,0,1, 1,0,0, 1,0,0,1, 0,0,0,0, 0,0);
    r(0,1,1, 1,0,0, 1,0,0,1, 0,0,0,0, 0,0);
    r(0,1,1, 1,0,0, 1,0,1,0, 0,0,0,0, 0,0);
    r(0,1,1, 1,0,0, 1,1,1,1, 0,0,0,0, 0,0);
    r(0,1,1, 1,0,0, 0,0,0,0, 1,0,0,1, 0,0);
    r(0,1,1, 1,0,0, 0,0,0,0, 1,0,1,0, 0,0);
    r(0,1,1, 1,0,0, 0,0,0,0, 1,1,1,1, 0,0);
    r(0,1,1, 1,0,0, 0,0,0,0, 0,0,0,0, 1,0);
    r(0,1,0, 1,0,0, 0,0,0,0, 0,0,0,0, 1,1);
    r(0,1,0, 1,0,0, 0,0,0,0, 0,0,0,0, 1,1);
    r(0,1,1, 1,0,0, 0,0,0,0, 0,0,0,0, 1,1);
    r(0,1,1, 1,0,0, 0,0,0,0, 0,0,0,0, 1,2);
    r(0,1,1, 1,0,0, 0,0,0,0, 0,0,0,0, 1,3);
    r(0,1,1, 1,1,0, 0,0,0,0, 0,0,0,0, 0,0);
    r(0,1,1, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0);
    // Scenario 1 again with a stray start at cycle 6 (rows 32..45)
    for (int k = 0; k < 14; k++) tab[32 + k] = tab[k];
    tab[38].st = 1;
    n = 46;
    // NBLK=1, PIPE_LAT=2 (rows 46..54)
    r(1,1,1, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0);
    r(0,1,1, 1,0,1, 0,0,0,0, 0,0,0,0, 0,0);
    r(0,1,1, 1,0,0, 1,0,0,1, 0,0,0,0, 0,0);
    r(0,1,1, 1,0,0, 0,0,0,0, 0,0,0,0, 0,0);
    r(0,1,1, 1,0,0, 0,0,0,0, 1,0,0,1, 0,0);
    r(0,1,1, 1,0,0, 0,0,0,0, 0,0,0,0, 1,0);
    r(0,1,1, 1,0,0, 0,0,0,0, 0,0,0,0, 1,1);
    r(0,1,1, 1,1,0, 0,0,0,0, 0,0,0,0, 0,0);
    r(0,1,1, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0);

    rst_n = 0; start = 0; num_steps = 16'd1;
    blk_ready = 1; int_ready = 1;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1;

    sel = 0;
    run_tab(0, 13);
    run_tab(14, 31);

    // Two timesteps
    num_steps = 16'd2;
    acc_m = 0; done_m = 0; rv_n = 0; ih_n = 0;
    @(negedge clk); start = 1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk); start = 0; #1;
      if (a_acc) acc_m |= 32'd1 << c;
      if (a_done) done_m |= 32'd1 << c;
      if (a_rv) rv_n++;
      if (a_iv && int_ready) ih_n++;
      if (c == 11) chk("step_count_s0", c, a_sc, 32'd0);
      if (c == 12) chk("step_count_s1", c, a_sc, 32'd1);
      if (c == 24) chk("busy_after_done", c, a_busy, 32'd0);
      if (c == 25) chk("step_count_hold", c, a_sc, 32'd1);
    end
    chk("acc_clr_cycles", 0, acc_m, (32'd1 << 1) | (32'd1 << 12));
    chk("done_cycles", 0, done_m, 32'd1 << 23);
    chk("res_valid_count", 0, rv_n, 32'd6);
    chk("int_handshakes", 0, ih_n, 32'd8);

    // Zero timesteps
    num_steps = 16'd0;
    done_m = 0; busy_m = 0; act = 0;
    @(negedge clk); start = 1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); start = 0; #1;
      if (a_done) done_m |= 32'd1 << c;
      if (a_busy) busy_m |= 32'd1 << c;
      act |= a_acc | a_bv | a_rv | a_iv;
    end
    chk("zero_done", 0, done_m, 32'd1 << 1);
    chk("zero_busy", 0, busy_m, 32'd1 << 1);
    chk("zero_activity", 0, act, 32'd0);
    num_steps = 16'd1;

    // Reset in cycle 3 of a run, then a clean rerun with a stray start
    run_tab(0, 3);
    rst_n = 0; #1;
    chk_zero("mid_reset");
    @(negedge clk); rst_n = 1;
    act = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      act |= a_rv | a_busy | b_rv | b_busy;
    end
    chk("no_res_after_reset", 0, act, 32'd0);
    run_tab(32, 45);

    sel = 1;
    repeat (3) @(negedge clk);
    run_tab(46, 54);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
